shift_seq: RTL
==============

Name: shift_seq

Overview:
Multi-cycle sequencer for the 16-bit shifter datapath. It applies one power-of-two shift stage per clock (8, 4, 2, then 1), reusing a single stage instance under FSM control. It sits between the execute-stage decoder and the writeback mux for shift/rotate instructions, and uses a Start/Busy/Done handshake so the pipeline can stall while a shift is in flight. Op encoding is shared with the combinational shifters:
- 00 rotate left
- 01 shift left
- 10 rotate right
- 11 shift right logical

Parameters:
WIDTH, 16, data width; must be a power of two
CNT_W, 4, shift-amount width, equal to log2(WIDTH); also the number of stages

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
Start  input  1  request; sampled only when Busy=0
In  input  WIDTH  operand, captured when Start is accepted
Op  input  2  operation, captured when Start is accepted
Cnt  input  CNT_W  shift amount 0..WIDTH-1, captured when Start is accepted
Flush  input  1  synchronous abort of the in-flight operation
Busy  output  1  high while the operation is in progress
Done  output  1  one-cycle pulse; Out is valid in this cycle
Out  output  WIDTH  result register; holds its value until the next completion

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset values: state=IDLE, Busy=0, Done=0, Out=0, working register=0, stage index=CNT_W-1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Start=1 at edge E0: capture In, Op, Cnt; load idx=CNT_W-1; go to RUN; Busy=1 from E0.
  - Start=0: stay in IDLE.
- RUN, each edge:
  - If Cnt_q[idx]=1: work <= stage(work, Op_q, 2^idx). Otherwise work is unchanged.
  - If idx=0: Out <= new work value; go to DONE.
  - Otherwise idx decrements.
- Fixed latency: 4 RUN edges (E1..E4). Done=1 and Busy=0 in the cycle after E4. Done is never asserted for more than one cycle.
- DONE:
  - Lasts exactly one cycle.
  - Start=1 here is accepted (back-to-back operation): go directly to RUN with new operands.
  - Otherwise go to IDLE.
- Start while in RUN: ignored, with no side effects. The requester must hold Start until Busy=0.
- Flush in RUN: return to IDLE at the next edge. Out is unchanged, Done is not pulsed, Busy=0 afterwards.
  - Flush in IDLE or DONE: no effect.
  - Flush and Start in the same DONE cycle: Flush wins and Start is dropped.
- rst mid-operation: immediately returns everything to the reset values, asynchronously.
- Cnt=0: the full 4-cycle sequence still runs and Out=In.
- Width rules:
  - Logical shifts zero-fill.
  - Rotates wrap bits around within WIDTH.
  - Composing the stages gives exact modulo-WIDTH rotation.
- Out changes only on the final RUN edge or on reset.

Optional Feature:
Macro SHIFT_SEQ_SKIP_EN.
- Defined:
  - At accept, idx loads the highest set bit of Cnt.
  - Each RUN edge applies stage idx, then jumps idx to the next lower set bit.
  - Zero bits cost no cycles, so RUN lasts max(1, popcount(Cnt)) edges.
  - Cnt=0 takes one RUN edge that passes the operand through; Done follows on the next cycle.
- Undefined: fixed 4-edge RUN as described above.
- Results are identical in both builds; only latency differs.

Decomposition:
- Package shift_pkg contains:
  - the Op encoding constants (OP_ROL, OP_SLL, OP_ROR, OP_SRL)
  - the FSM state typedef
  - the WIDTH/CNT_W defaults
- Sub-module shift_stage, purely combinational:
  - inputs: data, Op, and a one-hot-in-log2 amount selector
  - output: data shifted or rotated by 2^k
  - instantiated once in shift_seq

Test Plan:
- In=16'h8001, Op=00, Cnt=1, Start pulsed: Done exactly 5 cycles after the accept edge; Out=16'h0003.
- In=16'hF0F0, Op=11, Cnt=4: Out=16'h0F0F. Then Op=01, Cnt=15, In=16'hFFFF issued in the Done cycle: accepted back-to-back; Out=16'h8000; no IDLE cycle between the two operations.
- In=16'h0001, Op=10, Cnt=15: Out=16'h0002. Cnt=0 with In=16'hA5A5: Out=16'hA5A5.
- Start held high during RUN with different operands: ignored; the first result completes correctly. Exactly one Done per accepted request.
- Flush asserted on the 2nd RUN edge: no Done, Out holds its previous value, Busy=0 next cycle. rst asserted mid-RUN: Busy, Done and Out go to 0 immediately, without waiting for a clock edge.
- SHIFT_SEQ_SKIP_EN defined: Cnt=4'b1000 gives Done 2 cycles after accept; Cnt=4'b1111 gives Done 5 cycles after accept; Cnt=0 gives Done 2 cycles after accept. Out matches the non-skip build for 1000 random vectors.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shifter: op encoding, FSM states,
// default geometry and a small bit-scan helper used by the skip build.
`timescale 1ns/1ps
package shift_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 4;

  // Op encoding shared with the combinational shifters
  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index of the highest set bit; 0 when no bit is set.
  function automatic int unsigned msb_idx(input logic [31:0] v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One power-of-two shift/rotate stage: shifts data by 2^k according to op.
// Purely combinational; shift_seq reuses a single instance every cycle.
`timescale 1ns/1ps
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int IDX_W = (CNT_W > 1) ? $clog2(CNT_W) : 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  input  logic [IDX_W-1:0] k,
  output logic [WIDTH-1:0] result
);

  logic [CNT_W-1:0] amt;

  // Decode 2^k and apply the selected operation; amt never exceeds WIDTH/2,
  // so the complementary shift in the rotates stays below WIDTH.
  always_comb begin
    amt    = CNT_W'(1) << k;
    result = data;
    case (op)
      OP_ROL:  result = (data << amt) | (data >> (WIDTH - int'(amt)));
      OP_SLL:  result = data << amt;
      OP_ROR:  result = (data >> amt) | (data << (WIDTH - int'(amt)));
      default: result = data >> amt;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: applies stages 8,4,2,1 one per clock through a
// single shift_stage instance. Start/Busy/Done handshake toward the pipeline.
// Optional build macro SHIFT_SEQ_SKIP_EN: visit only the set bits of Cnt, so
// RUN lasts max(1, popcount(Cnt)) cycles; results are identical.
//
// Handshake: Start is sampled only while Busy=0 (IDLE or DONE); a request is
// accepted on the edge where Start=1 is seen in IDLE, or in DONE without
// Flush. Busy is high in every RUN cycle, Done is a single-cycle pulse in the
// cycle after the last RUN edge, and Out is valid from that cycle until the
// next completion. Flush aborts RUN at the next edge without a Done.
`timescale 1ns/1ps
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] In,
  input  logic [1:0]       Op,
  input  logic [CNT_W-1:0] Cnt,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out,
  output state_t           dbg_state
);

  localparam int IDX_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  state_t           state, state_next;
  logic [WIDTH-1:0] work;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx;

  logic             accept;
  logic             last;
  logic [IDX_W-1:0] idx_load;
  logic [IDX_W-1:0] idx_after;
  logic [WIDTH-1:0] stage_out;
  logic [WIDTH-1:0] work_step;

  shift_stage #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_stage (
    .data   (work),
    .op     (op_q),
    .k      (idx),
    .result (stage_out)
  );

  // Stage result is only taken when the current amount bit is set
  assign work_step = cnt_q[idx] ? stage_out : work;

`ifdef SHIFT_SEQ_SKIP_EN
  logic [CNT_W-1:0] below;

  // Jump straight between set bits of the amount; finish when none remain
  always_comb begin
    below     = cnt_q & ((CNT_W'(1) << idx) - CNT_W'(1));
    idx_load  = IDX_W'(msb_idx(32'(Cnt)));
    idx_after = IDX_W'(msb_idx(32'(below)));
    last      = (below == '0);
  end
`else
  // Walk every stage from the top bit down to bit 0
  always_comb begin
    idx_load  = IDX_W'(CNT_W - 1);
    idx_after = idx - IDX_W'(1);
    last      = (idx == '0);
  end
`endif

  // Next-state and request acceptance
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (Flush)     state_next = IDLE;
        else if (last) state_next = DONE;
      end
      DONE: begin
        if (Start && !Flush) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, operand capture, per-stage update and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      op_q  <= '0;
      cnt_q <= '0;
      idx   <= IDX_W'(CNT_W - 1);
      Out   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        work  <= In;
        op_q  <= Op;
        cnt_q <= Cnt;
        idx   <= idx_load;
      end else if (state == RUN && !Flush) begin
        work <= work_step;
        idx  <= idx_after;
        if (last) Out <= work_step;
      end
    end
  end

  assign Busy      = (state == RUN);
  assign Done      = (state == DONE);
  assign dbg_state = state;

endmodule
